// File: rtl/loader_pkg.sv
// Shared FSM state encoding, default parameters and width helper for the
// image loader sequencer.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_N_TGT      = 2;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_TIMEOUT    = 1024;

  // Index width that never collapses to zero bits for a single target.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; push while full is taken only
// together with a pop, pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/loader_seq.sv
// Boot-image loader: starts a debug-port init, streams buffered image words
// to the write serializer at incrementing addresses, then enables core fetch.
module loader_seq
  import loader_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned N_TGT      = DEF_N_TGT,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [clog2_min1(N_TGT)-1:0]   tgt_sel,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic                           init_start,
  input  logic                           init_done,
  output logic                           wr_valid,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  input  logic                           wr_ready,
  output logic [N_TGT-1:0]               fetch_en,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned TGT_W = clog2_min1(N_TGT);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [TGT_W-1:0]    tgt_q, tgt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_TGT-1:0]    fetch_q, fetch_d;
  logic                init_start_q, init_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W:0]     f_rdata;
  logic                f_full;
  logic                f_empty;
  logic [FCW-1:0]      f_count_unused;
  logic                f_push;
  logic                f_pop;
  logic                f_flush;
  logic                wr_xfer;

  // Stream side: accept whenever there is room, except while in error.
  assign s_ready  = !rst && (state_q != ST_ERR) && !f_full;
  assign f_push   = s_valid && s_ready;
  assign wr_valid = !rst && (state_q == ST_LOAD) && !f_empty;
  assign wr_data  = wr_valid ? f_rdata[DATA_W-1:0] : '0;
  assign wr_addr  = addr_q;
  assign wr_xfer  = wr_valid && wr_ready;
  assign f_pop    = wr_xfer;
  assign f_flush  = (state_q == ST_ERR) || (state_d == ST_ERR);

  assign init_start = init_start_q;
  assign fetch_en   = fetch_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (f_flush),
    .push_i  (f_push),
    .wdata_i ({s_last, s_data}),
    .pop_i   (f_pop),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count_unused)
  );

  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    fetch_d      = fetch_q;
    init_start_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          tgt_d   = tgt_sel;
          addr_d  = base_addr;
          cnt_d   = '0;
          fetch_d = '0;
          if (32'(tgt_sel) >= N_TGT) begin
            state_d = ST_ERR;
          end else begin
            init_start_d = 1'b1;
            state_d      = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        if (init_done) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Stall counter only runs while a write is offered and refused.
      ST_LOAD: begin
        if (wr_xfer) begin
          addr_d = addr_q + ADDR_W'(BYTES);
          cnt_d  = '0;
          if (f_rdata[DATA_W]) state_d = ST_FETCH;
        end else if (wr_valid) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) state_d = ST_ERR;
          else                              cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_FETCH: begin
        fetch_d = fetch_q | (N_TGT'(1) << tgt_q);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_INIT) || (state_d == ST_LOAD) || (state_d == ST_FETCH);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tgt_q        <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      fetch_q      <= '0;
      init_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      fetch_q      <= fetch_d;
      init_start_q <= init_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

endmodule
